counter_event_tracker: RTL and testbench

//  Downstream consumer of the 4-bit up/down counter. Samples the counter's control inputs
//  (load, up_down) and its data_out each clock, and classifies count transitions into events:

---
 rtl/counter_event_tracker_pkg.sv | 20 ++
 rtl/counter_event_tracker_if.sv | 31 +++
 rtl/counter_event_tracker_evt_fifo.sv | 53 +++++
 rtl/counter_event_tracker.sv | 125 ++++++++++++
 tb/tb_counter_event_tracker.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/counter_event_tracker_pkg.sv
// Shared types for the counter event tracker: event codes and the FIFO entry layout.
package counter_evt_pkg;

   localparam int unsigned CNT_WIDTH = 4;

   typedef enum logic [2:0] {
      EV_NONE    = 3'd0,
      EV_LOAD    = 3'd1,
      EV_WRAP_UP = 3'd2,
      EV_WRAP_DN = 3'd3,
      EV_THR_UP  = 3'd4,
      EV_THR_DN  = 3'd5
   } evt_code_e;

   typedef struct packed {
      evt_code_e              code;
      logic [CNT_WIDTH-1:0]   count;
   } evt_t;

endpackage

// File: rtl/counter_event_tracker_if.sv
// Bundle of counter-sample inputs and event-stream outputs of the event tracker.
interface counter_event_tracker_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
);
   import counter_evt_pkg::*;

   logic                   load;
   logic                   up_down;
   logic [WIDTH-1:0]       count_in;
   logic                   evt_valid;
   logic                   evt_ready;
   evt_code_e              evt_code;
   logic [WIDTH-1:0]       evt_count;
   logic [$clog2(DEPTH):0] evt_level;
   logic                   ovf_sticky;
   logic [7:0]             drop_cnt;

   // Counter side and event consumer
   modport master (
      output load, up_down, count_in, evt_ready,
      input  evt_valid, evt_code, evt_count, evt_level, ovf_sticky, drop_cnt
   );

   // Event tracker
   modport slave (
      input  load, up_down, count_in, evt_ready,
      output evt_valid, evt_code, evt_count, evt_level, ovf_sticky, drop_cnt
   );

endinterface

// File: rtl/counter_event_tracker_evt_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module evt_fifo
   import counter_evt_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = evt_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  T                       din,
   input  logic                   pop,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   T            mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   // Occupancy flags and handshake qualification; a pop on a full FIFO makes room for a push
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      level   = wr_ptr_q - rd_ptr_q;
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rd_ptr_q[AW-1:0]];
   end

   // Read/write pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Entry storage; contents are only observed through the pointers, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/counter_event_tracker.sv
// Classifies counter transitions into events and queues them for a valid/ready consumer.
module counter_event_tracker
   import counter_evt_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned THRESH = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   counter_event_tracker_if.slave   bus
);

   localparam int unsigned    LW  = $clog2(DEPTH) + 1;
   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

   typedef struct packed {
      evt_code_e          code;
      logic [WIDTH-1:0]   count;
   } entry_t;

   logic             prev_vld_q;
   logic             prev_load_q;
   logic             prev_ud_q;
   logic [WIDTH-1:0] prev_cnt_q;
   evt_code_e        code_d;
   entry_t           push_data;
   entry_t           head;
   entry_t           last_q;
   entry_t           shown;
   logic             push;
   logic             full;
   logic             empty;
   logic             drop;
   logic [LW-1:0]    level;
   logic             ovf_q;
   logic [7:0]       drop_q;

   // Previous-edge sample of the counter controls and value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_vld_q  <= 1'b0;
         prev_load_q <= 1'b0;
         prev_ud_q   <= 1'b0;
         prev_cnt_q  <= '0;
      end else begin
         prev_vld_q  <= 1'b1;
         prev_load_q <= bus.load;
         prev_ud_q   <= bus.up_down;
         prev_cnt_q  <= bus.count_in;
      end
   end

   // Priority classifier: at most one event per edge, load first
   always_comb begin
      code_d = EV_NONE;
      if (prev_vld_q) begin
         if (prev_load_q) begin
            code_d = EV_LOAD;
         end else if (prev_ud_q && prev_cnt_q == MAX && bus.count_in == '0) begin
            code_d = EV_WRAP_UP;
         end else if (!prev_ud_q && prev_cnt_q == '0 && bus.count_in == MAX) begin
            code_d = EV_WRAP_DN;
         end else if (prev_cnt_q < THR && bus.count_in >= THR) begin
            code_d = EV_THR_UP;
         end else if (prev_cnt_q >= THR && bus.count_in < THR) begin
            code_d = EV_THR_DN;
         end
      end
      push            = (code_d != EV_NONE);
      push_data.code  = code_d;
      push_data.count = bus.count_in;
      // Ready is only honoured when full if it really frees a slot this edge
      drop            = push && full && !bus.evt_ready;
   end

   evt_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_data),
      .pop   (bus.evt_ready),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Overflow flag and saturating drop counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   // Remember the last shown head so outputs hold steady once the FIFO drains
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= '0;
      end else if (!empty) begin
         last_q <= head;
      end
   end

   // Output view: live head while non-empty, held value otherwise
   always_comb begin
      shown = empty ? last_q : head;
   end

   assign bus.evt_valid  = !empty;
   assign bus.evt_code   = shown.code;
   assign bus.evt_count  = shown.count;
   assign bus.evt_level  = level;
   assign bus.ovf_sticky = ovf_q;
   assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_counter_event_tracker.sv
// Directed bench for counter_event_tracker with a queue-based reference model.
module tb_counter_event_tracker;
   import counter_evt_pkg::*;

   localparam int WIDTH  = 4;
   localparam int DEPTH  = 4;
   localparam int THRESH = 12;
   localparam int MAXV   = 15;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 0;

   counter_event_tracker_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   counter_event_tracker #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .THRESH (THRESH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int code;
      int cnt;
   } ev_t;

   ev_t q[$];
   int  m_pv, m_pl, m_pu, m_pc;
   int  m_last_code, m_last_cnt;
   int  m_ovf, m_drop;
   int  m_c, m_code;

   function automatic int classify(int pl, int pu, int pc, int c);
      if (pl != 0) return 1;
      if (pu != 0 && pc == MAXV && c == 0) return 2;
      if (pu == 0 && pc == 0 && c == MAXV) return 3;
      if (pc < THRESH && c >= THRESH) return 4;
      if (pc >= THRESH && c < THRESH) return 5;
      return 0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_pv = 0; m_pl = 0; m_pu = 0; m_pc = 0;
         m_last_code = 0; m_last_cnt = 0;
         m_ovf = 0; m_drop = 0;
      end else begin
         m_c    = int'(bus.count_in);
         m_code = (m_pv != 0) ? classify(m_pl, m_pu, m_pc, m_c) : 0;
         if (q.size() > 0) begin
            m_last_code = q[0].code;
            m_last_cnt  = q[0].cnt;
         end
         if (bus.evt_ready && q.size() > 0) void'(q.pop_front());
         if (m_code != 0) begin
            if (q.size() < DEPTH) begin
               q.push_back('{code: m_code, cnt: m_c});
            end else begin
               m_ovf = 1;
               if (m_drop < 255) m_drop++;
            end
         end
         m_pv = 1;
         m_pl = int'(bus.load);
         m_pu = int'(bus.up_down);
         m_pc = m_c;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (reset && cmp_en) begin
         chk("valid", int'(bus.evt_valid), int'(q.size() > 0));
         chk("level", int'(bus.evt_level), q.size());
         if (q.size() > 0) begin
            chk("head_code", int'(bus.evt_code), q[0].code);
            chk("head_count", int'(bus.evt_count), q[0].cnt);
         end else begin
            chk("hold_code", int'(bus.evt_code), m_last_code);
            chk("hold_count", int'(bus.evt_count), m_last_cnt);
         end
         chk("ovf", int'(bus.ovf_sticky), m_ovf);
         chk("drop", int'(bus.drop_cnt), m_drop);
      end
   end

   // Drive one edge's worth of inputs, then return at the following negedge
   task automatic cyc(input bit ld, input bit ud, input int cnt, input bit rdy);
      bus.load      = ld;
      bus.up_down   = ud;
      bus.count_in  = cnt[WIDTH-1:0];
      bus.evt_ready = rdy;
      @(negedge clk);
   endtask

   initial begin
      reset         = 1'b0;
      bus.load      = 1'b0;
      bus.up_down   = 1'b1;
      bus.count_in  = '0;
      bus.evt_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      cmp_en = 1;

      // Reset state
      chk("rst_valid", int'(bus.evt_valid), 0);
      chk("rst_level", int'(bus.evt_level), 0);
      chk("rst_code", int'(bus.evt_code), 0);
      chk("rst_count", int'(bus.evt_count), 0);
      chk("rst_ovf", int'(bus.ovf_sticky), 0);
      chk("rst_drop", int'(bus.drop_cnt), 0);

      // First edge yields nothing; 5->6 yields nothing; 11->12 crosses threshold
      cyc(0, 1, 5, 1);
      chk("first_edge_valid", int'(bus.evt_valid), 0);
      cyc(0, 1, 6, 1);
      chk("no_evt_valid", int'(bus.evt_valid), 0);
      cyc(0, 1, 11, 1);
      cyc(0, 1, 12, 1);
      chk("thr_up_valid", int'(bus.evt_valid), 1);
      chk("thr_up_code", int'(bus.evt_code), 4);
      chk("thr_up_count", int'(bus.evt_count), 12);

      // Wrap up then wrap down
      cyc(0, 1, 15, 1);
      cyc(0, 0, 0, 1);
      chk("wrap_up_code", int'(bus.evt_code), 2);
      chk("wrap_up_count", int'(bus.evt_count), 0);
      cyc(0, 0, 15, 1);
      chk("wrap_dn_code", int'(bus.evt_code), 3);
      chk("wrap_dn_count", int'(bus.evt_count), 15);
      cyc(0, 0, 14, 1);
      chk("drained_valid", int'(bus.evt_valid), 0);

      // Load beats threshold-up; load of an unchanged value still reports
      cyc(0, 0, 3, 1);
      cyc(1, 1, 3, 1);
      cyc(0, 1, 12, 1);
      chk("load12_code", int'(bus.evt_code), 1);
      chk("load12_count", int'(bus.evt_count), 12);
      cyc(0, 1, 7, 1);
      cyc(1, 1, 7, 1);
      cyc(0, 1, 7, 1);
      chk("load7_code", int'(bus.evt_code), 1);
      chk("load7_count", int'(bus.evt_count), 7);
      cyc(0, 1, 7, 1);
      chk("idle_hold_code", int'(bus.evt_code), 1);

      // Overflow: six loads with consumer stalled
      cyc(1, 1, 7, 0);
      for (int i = 1; i <= 6; i++) cyc(1, 1, i, 0);
      chk("ovf_level", int'(bus.evt_level), 4);
      chk("ovf_sticky", int'(bus.ovf_sticky), 1);
      chk("ovf_drop", int'(bus.drop_cnt), 2);
      chk("ovf_head_code", int'(bus.evt_code), 1);
      chk("ovf_head_count", int'(bus.evt_count), 1);

      // Full with simultaneous pop and push
      cyc(0, 1, 9, 1);
      chk("fullpp_level", int'(bus.evt_level), 4);
      chk("fullpp_head", int'(bus.evt_count), 2);
      chk("fullpp_drop", int'(bus.drop_cnt), 2);
      cyc(0, 1, 9, 1);
      chk("drain_level", int'(bus.evt_level), 3);
      chk("drain_head", int'(bus.evt_count), 3);

      // Reset mid-drain
      #2 reset = 1'b0;
      #1;
      chk("midrst_valid", int'(bus.evt_valid), 0);
      chk("midrst_level", int'(bus.evt_level), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc(0, 1, 13, 1);
      chk("post_rst_valid", int'(bus.evt_valid), 0);
      chk("post_rst_ovf", int'(bus.ovf_sticky), 0);
      cyc(0, 1, 11, 1);
      chk("post_rst_thr_dn", int'(bus.evt_code), 5);
      chk("post_rst_count", int'(bus.evt_count), 11);
      cyc(0, 1, 11, 1);
      cyc(0, 1, 11, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
